melody_seq: RTL and testbench
=============================

MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 Parameter: BEAT_MAX, 25'd24_999_999, beat length minus one in sys_clk cycles (0.5 s at 50 MHz).
REQ-002 Parameter: GAP_MAX, 22'd2_499_999, silent gap after each note minus one, in cycles.
REQ-003 Parameter: SONG_LEN, 6'd32, number of song ROM entries played (1..32).
REQ-004 Parameters: DO/RE/MI/FA/SO/LA/SI, 18'd190_839/170_067/151_514/143_265/127_550/113_635/101_214, tone period counts for the downstream beep.
REQ-005 sys_clk  in  1  system clock, 50 MHz; sole clock.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins the song from entry 0.
REQ-008 pause  in  1  one-cycle pulse; toggles pause/resume.
REQ-009 loop_en  in  1  level; 1 = restart at entry 0 after the last entry.
REQ-010 tone_en  out  1  1 = downstream beep sounds.
REQ-011 note_period  out  18  tone period count; duty = note_period/2 is derived downstream.
REQ-012 note_idx  out  5  current ROM entry index, for LED display.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a non-looping song ends.

Function
REQ-015 ROM entry (6 bits): note[2:0] (0 = rest, 1..7 = DO..SI) and beats[2:0] (duration = beats+1 beats).
REQ-016 States: IDLE, NOTE, GAP, PAUSE.
REQ-017 IDLE: tone_en=0, note_period=0, busy=0; start -> NOTE with note_idx=0.
REQ-018 NOTE: cycle counter runs 0..BEAT_MAX; beat counter increments on wrap; tone_en=(note!=0); note_period=table[note] (0 for a rest).
REQ-019 NOTE -> GAP on the cycle the counter wraps while the beat counter equals beats; both counters clear.
REQ-020 GAP: tone_en=0, note_period held, lasts GAP_MAX+1 cycles.
REQ-021 GAP end, note_idx<SONG_LEN-1: note_idx+1, -> NOTE.
REQ-022 GAP end, note_idx=SONG_LEN-1, loop_en=1: note_idx=0, -> NOTE.
REQ-023 GAP end, note_idx=SONG_LEN-1, loop_en=0: -> IDLE; done=1 for exactly that cycle.
REQ-024 All outputs are registered: tone_en rises one cycle after the start pulse is sampled.
REQ-025 pause in NOTE or GAP -> PAUSE: counters frozen, tone_en=0; the return state is saved.
REQ-026 pause in PAUSE -> resume the saved state with counters intact.
REQ-027 pause in IDLE: ignored.
REQ-028 start in any state other than IDLE: ignored.
REQ-029 start and pause in the same IDLE cycle: start wins.
REQ-030 Counters never exceed BEAT_MAX/GAP_MAX; note_idx never reaches SONG_LEN.

Reset
REQ-031 sys_rst_n=0 asynchronously forces IDLE, clears all counters, note_idx=0, and sets tone_en/note_period/busy/done to 0.
REQ-032 Reset asserted mid-note silences the output immediately; after release the block waits in IDLE for start.

Structure
REQ-033 Package melody_pkg: state encoding, ROM entry width and field positions, default note period constants.
REQ-034 Sub-module melody_rom: combinational 32x6 song table indexed by note_idx; the sequencer instantiates it.
REQ-035 Top-level integration: note_period and tone_en drive the existing beep block's period input and enable input.

Verification (BEAT_MAX=9, GAP_MAX=1, SONG_LEN=4; ROM = {DO,1b},{rest,0b},{MI,2b},{SI,0b})
REQ-036 Reset release, start at cycle t -> tone_en=1 and note_period=190_839 at t+1; tone_en stays high 20 cycles, then GAP for 2 cycles.
REQ-037 Rest entry -> tone_en=0 for 10 cycles, note_period=0, busy=1, note_idx=1.
REQ-038 loop_en=0, full song -> done pulses once after entry 3's gap; busy=0 and tone_en=0 on the next cycle.
REQ-039 loop_en=1 -> after entry 3's gap note_idx=0 and note_period=190_839; done never asserts.
REQ-040 pause on cycle 5 of MI, resume 7 cycles later -> tone_en=0 during the pause; MI sounds 25 more cycles (30 total).
REQ-041 sys_rst_n low mid-SI, then start pulses while busy -> outputs 0 immediately on reset; starts issued while busy leave note_idx and the counters unchanged.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module : melody_pkg
// Desc   : Shared types and constants for the melody sequencer: FSM state
//          encoding, song ROM entry layout and default tone period counts.
// Rev    : 1.0 - initial release
// ============================================================================
package melody_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NOTE  = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // ROM entry layout: {note[2:0], beats[2:0]}
  localparam int c_ENTRY_W   = 6;
  localparam int c_IDX_W     = 5;
  localparam int c_NOTE_MSB  = 5;
  localparam int c_NOTE_LSB  = 3;
  localparam int c_BEATS_MSB = 2;
  localparam int c_BEATS_LSB = 0;

  // Note codes stored in the ROM note field
  localparam logic [2:0] c_N_REST = 3'd0;
  localparam logic [2:0] c_N_DO   = 3'd1;
  localparam logic [2:0] c_N_RE   = 3'd2;
  localparam logic [2:0] c_N_MI   = 3'd3;
  localparam logic [2:0] c_N_FA   = 3'd4;
  localparam logic [2:0] c_N_SO   = 3'd5;
  localparam logic [2:0] c_N_LA   = 3'd6;
  localparam logic [2:0] c_N_SI   = 3'd7;

  // Default timing (50 MHz system clock)
  localparam logic [24:0] c_BEAT_MAX_DEF = 25'd24_999_999;
  localparam logic [21:0] c_GAP_MAX_DEF  = 22'd2_499_999;
  localparam logic [5:0]  c_SONG_LEN_DEF = 6'd32;

  // Default tone period counts for the downstream beep
  localparam logic [17:0] c_DO_DEF = 18'd190_839;
  localparam logic [17:0] c_RE_DEF = 18'd170_067;
  localparam logic [17:0] c_MI_DEF = 18'd151_514;
  localparam logic [17:0] c_FA_DEF = 18'd143_265;
  localparam logic [17:0] c_SO_DEF = 18'd127_550;
  localparam logic [17:0] c_LA_DEF = 18'd113_635;
  localparam logic [17:0] c_SI_DEF = 18'd101_214;

endpackage
`default_nettype wire

// File: rtl/melody_rom.sv
`default_nettype none
// ============================================================================
// Module : melody_rom
// Desc   : Combinational 32x6 song table. Each entry is {note, beats}; a note
//          lasts beats+1 beats, note 0 is a rest.
// Rev    : 1.0 - initial release
// ============================================================================
module melody_rom
  import melody_pkg::*;
(
  input  logic [c_IDX_W-1:0]   i_idx,
  output logic [c_ENTRY_W-1:0] o_entry
);

  // Song lookup; the first four entries form the short verification tune
  always_comb begin
    o_entry = {c_N_REST, 3'd0};
    case (i_idx)
      5'd0:  o_entry = {c_N_DO,   3'd1};
      5'd1:  o_entry = {c_N_REST, 3'd0};
      5'd2:  o_entry = {c_N_MI,   3'd2};
      5'd3:  o_entry = {c_N_SI,   3'd0};
      5'd4:  o_entry = {c_N_DO,   3'd0};
      5'd5:  o_entry = {c_N_DO,   3'd0};
      5'd6:  o_entry = {c_N_SO,   3'd0};
      5'd7:  o_entry = {c_N_SO,   3'd0};
      5'd8:  o_entry = {c_N_LA,   3'd0};
      5'd9:  o_entry = {c_N_LA,   3'd0};
      5'd10: o_entry = {c_N_SO,   3'd1};
      5'd11: o_entry = {c_N_REST, 3'd0};
      5'd12: o_entry = {c_N_FA,   3'd0};
      5'd13: o_entry = {c_N_FA,   3'd0};
      5'd14: o_entry = {c_N_MI,   3'd0};
      5'd15: o_entry = {c_N_MI,   3'd0};
      5'd16: o_entry = {c_N_RE,   3'd0};
      5'd17: o_entry = {c_N_RE,   3'd0};
      5'd18: o_entry = {c_N_DO,   3'd1};
      5'd19: o_entry = {c_N_REST, 3'd0};
      5'd20: o_entry = {c_N_SO,   3'd0};
      5'd21: o_entry = {c_N_SO,   3'd0};
      5'd22: o_entry = {c_N_FA,   3'd0};
      5'd23: o_entry = {c_N_FA,   3'd0};
      5'd24: o_entry = {c_N_MI,   3'd0};
      5'd25: o_entry = {c_N_MI,   3'd0};
      5'd26: o_entry = {c_N_RE,   3'd1};
      5'd27: o_entry = {c_N_REST, 3'd0};
      5'd28: o_entry = {c_N_SO,   3'd0};
      5'd29: o_entry = {c_N_FA,   3'd0};
      5'd30: o_entry = {c_N_MI,   3'd0};
      5'd31: o_entry = {c_N_DO,   3'd3};
      default: o_entry = {c_N_REST, 3'd0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/melody_seq.sv
`default_nettype none
// ============================================================================
// Module : melody_seq
// Desc   : Song sequencer. Walks the song ROM, holding each note for its beat
//          count followed by a short silent gap, with pause/resume, optional
//          looping and a done pulse. All outputs are registered and feed the
//          beep block's period and enable inputs.
// Rev    : 1.0 - initial release
// ============================================================================
module melody_seq
  import melody_pkg::*;
#(
  parameter logic [24:0] BEAT_MAX = c_BEAT_MAX_DEF,
  parameter logic [21:0] GAP_MAX  = c_GAP_MAX_DEF,
  parameter logic [5:0]  SONG_LEN = c_SONG_LEN_DEF,
  parameter logic [17:0] DO       = c_DO_DEF,
  parameter logic [17:0] RE       = c_RE_DEF,
  parameter logic [17:0] MI       = c_MI_DEF,
  parameter logic [17:0] FA       = c_FA_DEF,
  parameter logic [17:0] SO       = c_SO_DEF,
  parameter logic [17:0] LA       = c_LA_DEF,
  parameter logic [17:0] SI       = c_SI_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               loop_en,
  output logic               tone_en,
  output logic [17:0]        note_period,
  output logic [c_IDX_W-1:0] note_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [5:0] c_LAST_IDX = SONG_LEN - 6'd1;

  // Sequencer state
  state_t               r_state;
  state_t               r_ret_state;
  logic [24:0]          r_cyc_cnt;
  logic [2:0]           r_beat_cnt;
  logic [21:0]          r_gap_cnt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [2:0]           r_beats;

  // Registered outputs
  logic                 r_tone_en;
  logic [17:0]          r_note_period;
  logic                 r_busy;
  logic                 r_done;

  // Next-state values
  state_t               w_state_nxt;
  state_t               w_ret_nxt;
  logic [24:0]          w_cyc_nxt;
  logic [2:0]           w_beat_nxt;
  logic [21:0]          w_gap_nxt;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic                 w_done_nxt;
  logic                 w_tone_nxt;
  logic [17:0]          w_period_nxt;
  logic                 w_busy_nxt;

  logic [c_ENTRY_W-1:0] w_rom_entry;
  logic [2:0]           w_rom_note;
  logic [17:0]          w_period_lut;
  logic                 w_last;

  // The ROM is addressed with the upcoming index so the registered outputs
  // present the new note on the same edge that selects it.
  melody_rom u_rom (
    .i_idx   (w_idx_nxt),
    .o_entry (w_rom_entry)
  );

  assign w_rom_note = w_rom_entry[c_NOTE_MSB:c_NOTE_LSB];
  assign w_last     = ({1'b0, r_idx} == c_LAST_IDX);

  // Tone period table; a rest maps to 0
  always_comb begin
    w_period_lut = '0;
    case (w_rom_note)
      c_N_DO:  w_period_lut = DO;
      c_N_RE:  w_period_lut = RE;
      c_N_MI:  w_period_lut = MI;
      c_N_FA:  w_period_lut = FA;
      c_N_SO:  w_period_lut = SO;
      c_N_LA:  w_period_lut = LA;
      c_N_SI:  w_period_lut = SI;
      default: w_period_lut = '0;
    endcase
  end

  // Next-state logic: normal advance first, then a pause request overrides
  // the destination while keeping the advanced counters.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_cyc_nxt   = r_cyc_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_NOTE;
          w_idx_nxt   = '0;
          w_cyc_nxt   = '0;
          w_beat_nxt  = '0;
          w_gap_nxt   = '0;
        end
      end
      ST_NOTE: begin
        if (r_cyc_cnt == BEAT_MAX) begin
          w_cyc_nxt = '0;
          if (r_beat_cnt == r_beats) begin
            w_beat_nxt  = '0;
            w_gap_nxt   = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_beat_nxt = r_beat_cnt + 3'd1;
          end
        end else begin
          w_cyc_nxt = r_cyc_cnt + 25'd1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_MAX) begin
          w_gap_nxt = '0;
          if (!w_last) begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = ST_NOTE;
          end else if (loop_en) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_NOTE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_gap_nxt = r_gap_cnt + 22'd1;
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          w_state_nxt = r_ret_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A song that just finished stays finished even if pause arrives with it
    if (pause && ((r_state == ST_NOTE) || (r_state == ST_GAP)) &&
        (w_state_nxt != ST_IDLE)) begin
      w_ret_nxt   = w_state_nxt;
      w_state_nxt = ST_PAUSE;
    end
  end

  // Output values for the state being entered
  always_comb begin
    w_tone_nxt   = 1'b0;
    w_period_nxt = r_note_period;
    w_busy_nxt   = 1'b1;
    case (w_state_nxt)
      ST_IDLE: begin
        w_period_nxt = '0;
        w_busy_nxt   = 1'b0;
      end
      ST_NOTE: begin
        w_tone_nxt   = (w_rom_note != c_N_REST);
        w_period_nxt = w_period_lut;
      end
      default: begin
        w_tone_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_ret_state   <= ST_IDLE;
      r_cyc_cnt     <= '0;
      r_beat_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_idx         <= '0;
      r_beats       <= '0;
      r_tone_en     <= 1'b0;
      r_note_period <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_state   <= w_ret_nxt;
      r_cyc_cnt     <= w_cyc_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_idx         <= w_idx_nxt;
      r_beats       <= w_rom_entry[c_BEATS_MSB:c_BEATS_LSB];
      r_tone_en     <= w_tone_nxt;
      r_note_period <= w_period_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign tone_en     = r_tone_en;
  assign note_period = r_note_period;
  assign note_idx    = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_melody_seq
// Desc   : Scoreboard bench for melody_seq with a short beat/gap/song setup.
//          A remaining-cycles song model predicts every output cycle; a
//          monitor pops predictions and compares them with the DUT.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_melody_seq;

  localparam logic [24:0] BM = 25'd9;
  localparam logic [21:0] GM = 22'd1;
  localparam logic [5:0]  SL = 6'd4;
  localparam int BEAT_CYC = 10;
  localparam int GAP_CYC  = 2;
  localparam int SONG_N   = 4;
  localparam int M_IDLE = 0, M_SOUND = 1, M_GAP = 2, M_PAUSED = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        loop_en;
  logic        tone_en;
  logic [17:0] note_period;
  logic [4:0]  note_idx;
  logic        busy;
  logic        done;

  typedef struct {
    int tone;
    int period;
    int idx;
    int busy;
    int done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int period_tab [8] = '{0, 190839, 170067, 151514, 143265, 127550, 113635, 101214};
  int song_note  [4] = '{1, 0, 3, 7};
  int song_beats [4] = '{1, 0, 2, 0};

  // Song model: mode, remaining cycles of the current phase, saved mode
  int m_mode, m_saved, m_rem, m_idx, m_period, m_done;
  int mon_done_cnt, mon_mi_cnt;
  int wait_n;

  always #5 clk = ~clk;

  melody_seq #(
    .BEAT_MAX (BM),
    .GAP_MAX  (GM),
    .SONG_LEN (SL)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .start       (start),
    .pause       (pause),
    .loop_en     (loop_en),
    .tone_en     (tone_en),
    .note_period (note_period),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int note_len(input int i);
    return (song_beats[i] + 1) * BEAT_CYC;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tone   = (m_mode == M_SOUND && song_note[m_idx] != 0) ? 1 : 0;
    e.period = m_period;
    e.idx    = m_idx;
    e.busy   = (m_mode != M_IDLE) ? 1 : 0;
    e.done   = m_done;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_saved = M_IDLE; m_rem = 0;
    m_idx = 0; m_period = 0; m_done = 0;
  endtask

  // One clock of song behaviour given the inputs sampled at that edge
  task automatic model_step(input int s, input int p, input int le);
    m_done = 0;
    if (m_mode == M_IDLE) begin
      if (s != 0) begin
        m_idx = 0; m_mode = M_SOUND; m_rem = note_len(0);
      end
    end else if (m_mode == M_PAUSED) begin
      if (p != 0) m_mode = m_saved;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_mode == M_SOUND) begin
          m_mode = M_GAP; m_rem = GAP_CYC;
        end else if (m_idx < SONG_N - 1) begin
          m_idx++; m_mode = M_SOUND; m_rem = note_len(m_idx);
        end else if (le != 0) begin
          m_idx = 0; m_mode = M_SOUND; m_rem = note_len(0);
        end else begin
          m_mode = M_IDLE; m_done = 1;
        end
      end
      if (p != 0 && m_mode != M_IDLE) begin
        m_saved = m_mode; m_mode = M_PAUSED;
      end
    end
    if (m_mode == M_IDLE)       m_period = 0;
    else if (m_mode == M_SOUND) m_period = period_tab[song_note[m_idx]];
  endtask

  // Drive one cycle of inputs and queue the prediction for the next edge
  task automatic step_cycle(input logic r, input logic s, input logic p, input logic le);
    @(negedge clk);
    rst_n = r; start = s; pause = p; loop_en = le;
    if (!r) model_reset();
    else    model_step(int'(s), int'(p), int'(le));
    sb_q.push_back(model_out());
  endtask

  // Monitor: compare each registered output cycle against the prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("tone_en",     int'(tone_en),     e.tone);
        check("note_period", int'(note_period), e.period);
        check("note_idx",    int'(note_idx),    e.idx);
        check("busy",        int'(busy),        e.busy);
        check("done",        int'(done),        e.done);
        if (done) mon_done_cnt++;
        if (tone_en && note_period == 18'd151514) mon_mi_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mon_done_cnt = 0; mon_mi_cnt = 0;
    model_reset();
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; loop_en = 1'b0;
    #1;
    check("rst_tone",   int'(tone_en),     0);
    check("rst_period", int'(note_period), 0);
    check("rst_busy",   int'(busy),        0);
    check("rst_done",   int'(done),        0);
    check("rst_idx",    int'(note_idx),    0);
    repeat (3) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step_cycle(1'b1, 1'b0, 1'b1, 1'b0);  // pause in IDLE ignored

    // Full song without looping, start and pause together
    mon_done_cnt = 0;
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (85) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("song_done_pulses", mon_done_cnt, 1);

    // Looping song: done must never assert
    mon_done_cnt = 0;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (170) step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("loop_done_pulses", mon_done_cnt, 0);
    repeat (90) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Pause on the fifth MI cycle, resume seven cycles later
    mon_mi_cnt = 0;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    wait_n = 0;
    while (!(m_mode == M_SOUND && m_idx == 2) && wait_n < 200) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      wait_n++;
    end
    if (wait_n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL reach_mi: actual=timeout required=MI reached");
    end
    repeat (4) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (60) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mi_tone_cycles", mon_mi_cnt, 30);

    // Asynchronous reset in the middle of SI
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    wait_n = 0;
    while (!(m_mode == M_SOUND && m_idx == 3) && wait_n < 200) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      wait_n++;
    end
    if (wait_n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL reach_si: actual=timeout required=SI reached");
    end
    repeat (3) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tone",   int'(tone_en),     0);
    check("async_rst_period", int'(note_period), 0);
    check("async_rst_busy",   int'(busy),        0);
    check("async_rst_idx",    int'(note_idx),    0);
    model_reset();
    sb_q.delete(sb_q.size() - 1);
    sb_q.push_back(model_out());
    repeat (2) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);  // waits in IDLE
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 70; k++)
      step_cycle(1'b1, (k % 7) == 0, 1'b0, 1'b0);    // starts while busy

    // Randomized traffic
    begin
      logic r_l, s_l, p_l, le_l;
      le_l = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        r_l = ($urandom_range(399, 0) != 0);
        s_l = ($urandom_range(24, 0) == 0);
        p_l = ($urandom_range(39, 0) == 0);
        if ($urandom_range(99, 0) == 0) le_l = ~le_l;
        step_cycle(r_l, s_l, p_l, le_l);
      end
    end

    repeat (4) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    wait_n = 0;
    while (sb_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
